mem_stage_access_ctrl: RTL and testbench
========================================

Name: mem_stage_access_ctrl

Overview:
- Sequences every load/store in the MEM stage of the pipelined RV32I core.
- Routes data-RAM accesses as single-cycle pass-through (byte enables and lane-replicated write data).
- Runs peripheral accesses (is_per_m=1) as a req/ack bus transaction with timeout, holding the EXE/MEM register via stall_m until the transaction completes.
- Also detects misaligned accesses and suppresses them.

Parameters:
- TIMEOUT, 16, max cycles per_req stays high without per_ack before the access is aborted (≥1).
- ERR_RDATA, 32'h0000_0000, read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mem_read_m  in  1  load in MEM stage
- mem_write_m  in  1  store in MEM stage
- is_per_m  in  1  address targets peripheral space
- mem_size_m  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- addr_m  in  32  ALU result (byte address)
- wdata_m  in  32  store data, right-aligned
- ext_stall_m  in  1  MEM stage held by another hazard source
- stall_m  out  1  to hazard unit; freezes the EXE/MEM register and earlier stages
- dmem_we  out  1  data-RAM write strobe
- dmem_be  out  4  data-RAM byte enables
- dmem_wdata  out  32  lane-replicated write data
- per_req  out  1  peripheral request
- per_we  out  1  peripheral write
- per_addr  out  32  latched address
- per_be  out  4  latched byte enables
- per_wdata  out  32  latched lane-replicated data
- per_ack  in  1  peripheral completion, one-cycle pulse
- per_rdata  in  32  peripheral read data, valid with per_ack
- per_rdata_m  out  32  captured peripheral read data for writeback mux
- misalign_err  out  1  combinational; current access is misaligned
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- access = (mem_read_m | mem_write_m) & ~misalign.
- misalign:
  - half: addr_m[0]=1
  - word: addr_m[1:0]≠0
  - byte: never misaligned
- A misaligned access issues nothing: dmem_we=0, per_req stays low, stall_m=0. misalign_err=1 for as long as the access sits in MEM.
- Byte enables:
  - byte: 4'b0001<<addr_m[1:0]
  - half: 4'b0011<<{addr_m[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{wdata_m[7:0]}}
  - half: {2{wdata_m[15:0]}}
  - word: as-is
- Data-RAM path (is_per_m=0), combinational, no stall:
  - dmem_we = mem_write_m & access & ~is_per_m
  - dmem_be valid whenever access
- FSM states IDLE, REQ, DONE. Reset state IDLE.
- IDLE:
  - If access & is_per_m: latch per_addr/per_be/per_wdata/per_we, clear the timeout counter, go to REQ.
  - stall_m = access & is_per_m.
- REQ:
  - per_req=1 and stall_m=1. Latched outputs stay stable throughout.
  - Counter increments each cycle.
  - On per_ack: capture per_rdata into per_rdata_m, go to DONE.
  - If the counter reaches TIMEOUT-1 without per_ack: per_rdata_m←ERR_RDATA, pulse bus_err next cycle, go to DONE, drop per_req.
  - per_ack arriving on the timeout cycle wins; no bus_err.
- DONE:
  - stall_m=0 and per_req=0.
  - If ext_stall_m=1, stay in DONE so the same access is not reissued. Otherwise go to IDLE.
- Minimum peripheral latency: 2 stall cycles (IDLE, REQ with same-cycle ack), then DONE. The pipeline advances at the end of DONE.
- per_ack outside REQ is ignored.
- Reset values:
  - all registered outputs 0
  - per_rdata_m=0, bus_err=0, per_req=0
  - FSM IDLE
- Reset mid-transaction drops per_req immediately (async). The peripheral must tolerate an abandoned request.
- Back-to-back peripheral accesses: the second one starts from IDLE in the cycle after DONE.

Test Plan:
1. Data-RAM store: mem_size=00, addr=0x1003, wdata=0xAB → dmem_be=4'b1000, dmem_wdata=0xABABABAB, dmem_we=1, stall_m=0 throughout.
2. Peripheral load, ack in first REQ cycle, per_rdata=0x1234_5678 → stall_m high 2 cycles, per_req high 1 cycle, per_rdata_m=0x12345678 in DONE, bus_err=0.
3. Peripheral store, half, addr=0x4000_0002, ack after 5 cycles → per_be=4'b1100, per_we=1, per_addr stable for all 5 REQ cycles, stall_m high 6 cycles.
4. Peripheral load with no ack, TIMEOUT=16 → per_req high exactly 16 cycles, bus_err single pulse, per_rdata_m=ERR_RDATA, FSM back to IDLE.
5. Word load at addr=0x4000_0001 (is_per_m=1) → misalign_err=1, per_req never asserted, stall_m=0.
6. rst asserted during REQ → per_req=0, stall_m=0, state IDLE immediately. A later per_ack is ignored. ext_stall_m=1 in DONE holds DONE and no second per_req occurs.

Source files
------------

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage load/store sequencer: single-cycle data-RAM pass-through plus a
// req/ack peripheral transaction with timeout that holds the pipeline via stall_m.
//
// Peripheral handshake: per_req rises in the cycle after the access is seen in
// IDLE and stays high, with per_addr/per_be/per_wdata/per_we frozen, until
// either a one-cycle per_ack pulse or the timeout ends it. per_ack outside REQ
// is ignored.
module mem_stage_access_ctrl #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic        is_per_m,
  input  logic [1:0]  mem_size_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        ext_stall_m,
  output logic        stall_m,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        per_req,
  output logic        per_we,
  output logic [31:0] per_addr,
  output logic [3:0]  per_be,
  output logic [31:0] per_wdata,
  input  logic        per_ack,
  input  logic [31:0] per_rdata,
  output logic [31:0] per_rdata_m,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [1:0]  stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  stateT         state, nextState;
  logic [CW-1:0] cnt;
  logic          isHalf, isWord, misalign, access;
  logic [3:0]    laneBe;
  logic [31:0]   laneData;
  logic          latchEn, ackTake, timeoutHit;

  // Size decode; the reserved encoding 11 behaves as a word access.
  assign isHalf = (mem_size_m == 2'b01);
  assign isWord = mem_size_m[1];

  always_comb begin
    misalign = 1'b0;
    if (isHalf)      misalign = addr_m[0];
    else if (isWord) misalign = |addr_m[1:0];
  end

  assign access       = (mem_read_m | mem_write_m) & ~misalign;
  assign misalign_err = (mem_read_m | mem_write_m) & misalign;

  always_comb begin
    laneBe   = 4'b1111;
    laneData = wdata_m;
    if (isHalf) begin
      laneBe   = 4'b0011 << {addr_m[1], 1'b0};
      laneData = {2{wdata_m[15:0]}};
    end else if (!isWord) begin
      laneBe   = 4'b0001 << addr_m[1:0];
      laneData = {4{wdata_m[7:0]}};
    end
  end

  assign dmem_we    = mem_write_m & access & ~is_per_m;
  assign dmem_be    = access ? laneBe : 4'b0000;
  assign dmem_wdata = laneData;

  assign per_req  = (state == REQ);
  assign stateDbg = state;

  always_comb begin
    nextState  = state;
    stall_m    = 1'b0;
    latchEn    = 1'b0;
    ackTake    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (access && is_per_m) begin
          stall_m   = 1'b1;
          latchEn   = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        stall_m = 1'b1;
        // An ack landing on the final counted cycle still completes normally.
        if (per_ack) begin
          ackTake   = 1'b1;
          nextState = DONE;
        end else if (cnt == LAST) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      DONE: begin
        // Hold while another hazard freezes MEM so the access is not reissued.
        if (!ext_stall_m) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      per_we      <= 1'b0;
      per_addr    <= 32'h0;
      per_be      <= 4'h0;
      per_wdata   <= 32'h0;
      per_rdata_m <= 32'h0;
      bus_err     <= 1'b0;
    end else begin
      state   <= nextState;
      bus_err <= timeoutHit;
      if (latchEn) begin
        per_we    <= mem_write_m;
        per_addr  <= addr_m;
        per_be    <= laneBe;
        per_wdata <= laneData;
        cnt       <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (ackTake)         per_rdata_m <= per_rdata;
      else if (timeoutHit) per_rdata_m <= ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl: a vector table for the data-RAM and
// misalign paths, plus hand-written peripheral transaction sequences.
module tb_mem_stage_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_m = 0, mem_write_m = 0, is_per_m = 0, ext_stall_m = 0;
  logic [1:0]  mem_size_m = 0;
  logic [31:0] addr_m = 0, wdata_m = 0, per_rdata = 0;
  logic        per_ack = 0;
  logic        stall_m, dmem_we, per_req, per_we, misalign_err, bus_err;
  logic [3:0]  dmem_be, per_be;
  logic [31:0] dmem_wdata, per_addr, per_wdata, per_rdata_m;
  logic [1:0]  stateDbg;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;

  mem_stage_access_ctrl #(.TIMEOUT(16), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .is_per_m(is_per_m), .mem_size_m(mem_size_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .ext_stall_m(ext_stall_m), .stall_m(stall_m), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_be(per_be), .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata),
    .per_rdata_m(per_rdata_m), .misalign_err(misalign_err), .bus_err(bus_err),
    .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    logic        rd, wr, per;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expMis;
  } vecT;

  vecT vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic per, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_read_m  = rd;
    mem_write_m = wr;
    is_per_m    = per;
    mem_size_m  = size;
    addr_m      = addr;
    wdata_m     = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    int reqCnt, pulses;
    logic seenDone;

    vecs[0]  = '{0, 1, 0, 2'b00, 32'h0000_1003, 32'h0000_00AB, 1, 4'b1000, 32'hABAB_ABAB, 0};
    vecs[1]  = '{1, 0, 0, 2'b00, 32'h0000_1000, 32'h1122_3344, 0, 4'b0001, 32'h4444_4444, 0};
    vecs[2]  = '{0, 1, 0, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 0};
    vecs[3]  = '{0, 1, 0, 2'b01, 32'h0000_2000, 32'h0000_CAFE, 1, 4'b0011, 32'hCAFE_CAFE, 0};
    vecs[4]  = '{0, 1, 0, 2'b10, 32'h0000_3000, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678, 0};
    vecs[5]  = '{0, 1, 0, 2'b11, 32'h0000_3004, 32'h8765_4321, 1, 4'b1111, 32'h8765_4321, 0};
    vecs[6]  = '{0, 1, 0, 2'b01, 32'h0000_2001, 32'h0000_5A5A, 0, 4'b0000, 32'h5A5A_5A5A, 1};
    vecs[7]  = '{1, 0, 0, 2'b10, 32'h0000_3002, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 1};
    vecs[8]  = '{1, 0, 1, 2'b10, 32'h4000_0001, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 1};
    vecs[9]  = '{0, 0, 0, 2'b10, 32'h0000_0003, 32'h55AA_55AA, 0, 4'b0000, 32'h55AA_55AA, 0};
    vecs[10] = '{0, 1, 0, 2'b00, 32'h0000_1002, 32'h0000_00FF, 1, 4'b0100, 32'hFFFF_FFFF, 0};

    // Asynchronous reset state, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_per_req", 32'(per_req), 32'd0);
    chk("rst_rdata_m", per_rdata_m, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_state", 32'(stateDbg), 32'(S_IDLE));
    chk("rst_per_addr", per_addr, 32'h0);
    chk("rst_per_be", 32'(per_be), 32'h0);
    nextCycle();
    rst = 1'b1;

    // Data-RAM pass-through and misalign table.
    for (int i = 0; i < 11; i++) begin
      nextCycle();
      drive(vecs[i].rd, vecs[i].wr, vecs[i].per, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      settle();
      chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].expWe));
      chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].expBe));
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].expWdata);
      chk($sformatf("v%0d_mis", i), 32'(misalign_err), 32'(vecs[i].expMis));
      chk($sformatf("v%0d_stall", i), 32'(stall_m), 32'd0);
      chk($sformatf("v%0d_req", i), 32'(per_req), 32'd0);
    end
    nextCycle();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("mis_per_state", 32'(stateDbg), 32'(S_IDLE));

    // Peripheral load, ack in the first REQ cycle.
    nextCycle();
    drive(1, 0, 1, 2'b10, 32'h4000_0010, 32'h0);
    settle();
    chk("ld_idle_stall", 32'(stall_m), 32'd1);
    chk("ld_idle_req", 32'(per_req), 32'd0);
    nextCycle();
    per_ack = 1; per_rdata = 32'h1234_5678;
    settle();
    chk("ld_req_stall", 32'(stall_m), 32'd1);
    chk("ld_req_req", 32'(per_req), 32'd1);
    chk("ld_req_addr", per_addr, 32'h4000_0010);
    chk("ld_req_be", 32'(per_be), 32'hF);
    chk("ld_req_we", 32'(per_we), 32'd0);
    nextCycle();
    per_ack = 0; per_rdata = 32'h0;
    settle();
    chk("ld_done_stall", 32'(stall_m), 32'd0);
    chk("ld_done_req", 32'(per_req), 32'd0);
    chk("ld_done_rdata", per_rdata_m, 32'h1234_5678);
    chk("ld_done_berr", 32'(bus_err), 32'd0);
    chk("ld_done_state", 32'(stateDbg), 32'(S_DONE));
    nextCycle();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("ld_back_idle", 32'(stateDbg), 32'(S_IDLE));

    // Peripheral half store, ack in the fifth REQ cycle; address bus wiggles meanwhile.
    nextCycle();
    drive(0, 1, 1, 2'b01, 32'h4000_0002, 32'h0000_BEEF);
    settle();
    chk("st_idle_stall", 32'(stall_m), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      addr_m = 32'h4000_0002 ^ (32'(i) << 4);
      if (i == 5) begin
        per_ack = 1; per_rdata = 32'h0BAD_F00D;
      end
      settle();
      chk($sformatf("st_r%0d_stall", i), 32'(stall_m), 32'd1);
      chk($sformatf("st_r%0d_req", i), 32'(per_req), 32'd1);
      chk($sformatf("st_r%0d_addr", i), per_addr, 32'h4000_0002);
      chk($sformatf("st_r%0d_be", i), 32'(per_be), 32'hC);
      chk($sformatf("st_r%0d_we", i), 32'(per_we), 32'd1);
      chk($sformatf("st_r%0d_wdata", i), per_wdata, 32'hBEEF_BEEF);
    end
    nextCycle();
    per_ack = 0;
    settle();
    chk("st_done_stall", 32'(stall_m), 32'd0);
    chk("st_done_state", 32'(stateDbg), 32'(S_DONE));
    chk("st_done_rdata", per_rdata_m, 32'h0BAD_F00D);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0);

    // Peripheral load with no ack: timeout after 16 request cycles.
    nextCycle();
    drive(1, 0, 1, 2'b10, 32'h4000_0020, 32'h0);
    reqCnt = 0; pulses = 0; seenDone = 0;
    nextCycle();
    for (int k = 0; k < 30; k++) begin
      settle();
      if (per_req) reqCnt++;
      if (bus_err) pulses++;
      if (stateDbg == S_DONE && !seenDone) begin
        seenDone = 1;
        chk("to_done_berr", 32'(bus_err), 32'd1);
        chk("to_done_rdata", per_rdata_m, 32'h0000_0000);
        drive(0, 0, 0, 0, 0, 0);
      end
      nextCycle();
    end
    chk("to_req_cycles", 32'(reqCnt), 32'd16);
    chk("to_berr_pulses", 32'(pulses), 32'd1);
    chk("to_seen_done", 32'(seenDone), 32'd1);
    chk("to_end_state", 32'(stateDbg), 32'(S_IDLE));

    // Ack arriving on the last timeout cycle wins.
    drive(1, 0, 1, 2'b10, 32'h4000_0030, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      nextCycle();
      if (k == 16) begin
        per_ack = 1; per_rdata = 32'hCAFE_F00D;
      end
      settle();
      chk($sformatf("late_r%0d_req", k), 32'(per_req), 32'd1);
    end
    nextCycle();
    per_ack = 0;
    settle();
    chk("late_state", 32'(stateDbg), 32'(S_DONE));
    chk("late_berr", 32'(bus_err), 32'd0);
    chk("late_rdata", per_rdata_m, 32'hCAFE_F00D);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0);

    // Reset in the middle of REQ drops the request at once.
    nextCycle();
    drive(1, 0, 1, 2'b10, 32'h4000_0040, 32'h0);
    nextCycle();
    settle();
    chk("rr_req_before", 32'(per_req), 32'd1);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rr_req", 32'(per_req), 32'd0);
    chk("rr_stall", 32'(stall_m), 32'd0);
    chk("rr_state", 32'(stateDbg), 32'(S_IDLE));
    chk("rr_rdata", per_rdata_m, 32'h0);
    nextCycle();
    rst = 1'b1;
    per_ack = 1; per_rdata = 32'hFFFF_FFFF;
    settle();
    chk("stray_ack_state", 32'(stateDbg), 32'(S_IDLE));
    nextCycle();
    per_ack = 0;
    settle();
    chk("stray_ack_state2", 32'(stateDbg), 32'(S_IDLE));
    chk("stray_ack_rdata", per_rdata_m, 32'h0);

    // ext_stall_m holds DONE without a second request.
    nextCycle();
    drive(1, 0, 1, 2'b10, 32'h4000_0050, 32'h0);
    nextCycle();
    per_ack = 1; per_rdata = 32'h600D_CAFE;
    nextCycle();
    per_ack = 0;
    ext_stall_m = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("hold%0d_state", k), 32'(stateDbg), 32'(S_DONE));
      chk($sformatf("hold%0d_req", k), 32'(per_req), 32'd0);
      chk($sformatf("hold%0d_stall", k), 32'(stall_m), 32'd0);
      nextCycle();
    end
    ext_stall_m = 0;
    settle();
    chk("hold_release_state", 32'(stateDbg), 32'(S_DONE));
    nextCycle();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("hold_end_state", 32'(stateDbg), 32'(S_IDLE));
    chk("hold_end_req", 32'(per_req), 32'd0);
    chk("hold_end_rdata", per_rdata_m, 32'h600D_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
